// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: funct3 codes, FSM states,
// error codes, and the load/store decode helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_FUNCT3   = 2'd2
  } err_e;

  // Stores only exist for B/H/W; unsigned variants are load-only.
  function automatic err_e data_err_code(input logic write, input logic [2:0] f3,
                                         input logic [1:0] lo);
    err_e code;
    code = ERR_NONE;
    case (f3)
      F3_B:  code = ERR_NONE;
      F3_H:  if (lo[0]) code = ERR_MISALIGN;
      F3_W:  if (lo != 2'b00) code = ERR_MISALIGN;
      F3_BU: if (write) code = ERR_FUNCT3;
      F3_HU: begin
        if (write) code = ERR_FUNCT3;
        else if (lo[0]) code = ERR_MISALIGN;
      end
      default: code = ERR_FUNCT3;
    endcase
    return code;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] r;
    r = 32'h0;
    case (f3)
      F3_B:  r = {{24{w[7]}}, w[7:0]};
      F3_H:  r = {{16{w[15]}}, w[15:0]};
      F3_W:  r = w;
      F3_BU: r = {24'h0, w[7:0]};
      F3_HU: r = {16'h0, w[15:0]};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3);
    logic [3:0] be;
    be = 4'b0000;
    case (f3)
      F3_B:    be = 4'b0001;
      F3_H:    be = 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-wide storage with four read lanes at addr+0..+3 (wrapping) and a
// lane-relative byte-enable write. Contents are never reset.
module mem_byte_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [3:0]        i_we,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] w_lane_addr [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_addr[gi]       = i_addr + ADDR_W'(gi);
      assign o_rdata[8*gi +: 8]    = r_mem[w_lane_addr[gi]];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) r_mem[w_lane_addr[i]] <= i_wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder arbitrating fetch and load/store requests,
// with configurable wait states and registered one-cycle response pulses.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  output logic              if_rsp_err,
  input  logic              d_req_valid,
  input  logic              d_req_write,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [31:0]       d_req_wdata,
  input  logic [2:0]        d_req_func3,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_rdata,
  output logic              d_rsp_err
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  state_e            r_state, w_state_next;
  logic [CNT_W-1:0]  r_wait_cnt;

  logic              r_req_data, r_req_write;
  logic [ADDR_W-1:0] r_req_addr;
  logic [31:0]       r_req_wdata;
  logic [2:0]        r_req_func3;

  logic              r_if_rsp_valid, r_if_rsp_err, r_d_rsp_valid, r_d_rsp_err;
  logic [31:0]       r_if_rsp_data, r_d_rsp_rdata;

  logic              w_if_ready, w_d_ready, w_accept, w_enter_resp;
  logic              w_cur_data, w_cur_write;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [31:0]       w_cur_wdata, w_rdata;
  logic [2:0]        w_cur_func3;
  err_e              w_err_code;
  logic              w_err;
  logic [3:0]        w_mem_we;

  always_comb begin
    w_state_next = r_state;
    w_if_ready   = 1'b0;
    w_d_ready    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst && d_req_valid) begin
          w_d_ready = 1'b1;
          w_accept  = 1'b1;
        end else if (!rst && if_req_valid) begin
          w_if_ready = 1'b1;
          w_accept   = 1'b1;
        end
        if (w_accept) w_state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
      end
      WAIT:    if (r_wait_cnt == '0) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // The RESP-entry edge may coincide with accept when there are no wait
  // states, so the access uses the incoming request while still in IDLE.
  always_comb begin
    if (r_state == IDLE) begin
      w_cur_data  = w_d_ready;
      w_cur_write = w_d_ready & d_req_write;
      w_cur_addr  = w_d_ready ? d_req_addr : if_req_addr;
      w_cur_wdata = d_req_wdata;
      w_cur_func3 = d_req_func3;
    end else begin
      w_cur_data  = r_req_data;
      w_cur_write = r_req_write;
      w_cur_addr  = r_req_addr;
      w_cur_wdata = r_req_wdata;
      w_cur_func3 = r_req_func3;
    end
  end

  assign w_enter_resp = !rst && (w_state_next == RESP) && (r_state != RESP);
  assign w_err_code   = w_cur_data ? data_err_code(w_cur_write, w_cur_func3, w_cur_addr[1:0])
                                   : (w_cur_addr[0] ? ERR_MISALIGN : ERR_NONE);
  assign w_err        = (w_err_code != ERR_NONE);
  assign w_mem_we     = (w_enter_resp && w_cur_data && w_cur_write && !w_err)
                        ? store_be(w_cur_func3) : 4'b0000;

  mem_byte_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .i_addr  (w_cur_addr),
    .i_we    (w_mem_we),
    .i_wdata (w_cur_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_req_data  <= w_d_ready;
      r_req_write <= d_req_write;
      r_req_addr  <= w_cur_addr;
      r_req_wdata <= d_req_wdata;
      r_req_func3 <= d_req_func3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_wait_cnt     <= '0;
      r_if_rsp_valid <= 1'b0;
      r_if_rsp_data  <= 32'h0;
      r_if_rsp_err   <= 1'b0;
      r_d_rsp_valid  <= 1'b0;
      r_d_rsp_rdata  <= 32'h0;
      r_d_rsp_err    <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_if_rsp_valid <= 1'b0;
      r_d_rsp_valid  <= 1'b0;
      if (w_accept) r_wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
      else if (r_state == WAIT && r_wait_cnt != '0) r_wait_cnt <= r_wait_cnt - 1'b1;
      if (w_enter_resp) begin
        if (w_cur_data) begin
          r_d_rsp_valid <= 1'b1;
          r_d_rsp_err   <= w_err;
          r_d_rsp_rdata <= (w_err || w_cur_write) ? 32'h0 : load_extend(w_cur_func3, w_rdata);
        end else begin
          r_if_rsp_valid <= 1'b1;
          r_if_rsp_err   <= w_err;
          r_if_rsp_data  <= w_err ? 32'h0 : w_rdata;
        end
      end
    end
  end

  assign if_req_ready = w_if_ready;
  assign d_req_ready  = w_d_ready;
  assign if_rsp_valid = r_if_rsp_valid;
  assign if_rsp_data  = r_if_rsp_data;
  assign if_rsp_err   = r_if_rsp_err;
  assign d_rsp_valid  = r_d_rsp_valid;
  assign d_rsp_rdata  = r_d_rsp_rdata;
  assign d_rsp_err    = r_d_rsp_err;

endmodule

// File: tb/tb_mem_responder.sv
// Scenario bench for mem_responder: expected responses are queued when a
// request is accepted and compared when the matching response pulse arrives.
module tb_mem_responder;

  localparam int AW = 10;
  localparam int WC = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid;
  logic [AW-1:0] if_req_addr;
  logic          if_req_ready;
  logic          if_rsp_valid;
  logic [31:0]   if_rsp_data;
  logic          if_rsp_err;
  logic          d_req_valid;
  logic          d_req_write;
  logic [AW-1:0] d_req_addr;
  logic [31:0]   d_req_wdata;
  logic [2:0]    d_req_func3;
  logic          d_req_ready;
  logic          d_rsp_valid;
  logic [31:0]   d_rsp_rdata;
  logic          d_rsp_err;

  mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_func3(d_req_func3), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  exp_t d_exp_q[$];
  exp_t if_exp_q[$];
  exp_t d_e, if_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (d_rsp_valid === 1'b1) begin
      checks++;
      if (d_exp_q.size() == 0) begin
        errors++;
        $display("FAIL d_rsp_unexpected rdata=%h err=%b required no response", d_rsp_rdata, d_rsp_err);
      end else begin
        d_e = d_exp_q.pop_front();
        if (d_rsp_rdata !== d_e.data || d_rsp_err !== d_e.err) begin
          errors++;
          $display("FAIL %s rdata=%h err=%b required rdata=%h err=%b",
                   d_e.name, d_rsp_rdata, d_rsp_err, d_e.data, d_e.err);
        end else $display("ok   %s rdata=%h err=%b", d_e.name, d_rsp_rdata, d_rsp_err);
      end
    end
    if (if_rsp_valid === 1'b1) begin
      checks++;
      if (if_exp_q.size() == 0) begin
        errors++;
        $display("FAIL if_rsp_unexpected data=%h err=%b required no response", if_rsp_data, if_rsp_err);
      end else begin
        if_e = if_exp_q.pop_front();
        if (if_rsp_data !== if_e.data || if_rsp_err !== if_e.err) begin
          errors++;
          $display("FAIL %s data=%h err=%b required data=%h err=%b",
                   if_e.name, if_rsp_data, if_rsp_err, if_e.data, if_e.err);
        end else $display("ok   %s data=%h err=%b", if_e.name, if_rsp_data, if_rsp_err);
      end
    end
  end

  task automatic data_txn(input logic wr, input logic [2:0] f3, input logic [AW-1:0] a,
                          input logic [31:0] wd, input logic [31:0] er, input logic ee,
                          input string nm, output int acc);
    int n;
    d_req_valid = 1'b1; d_req_write = wr; d_req_func3 = f3; d_req_addr = a; d_req_wdata = wd;
    n = 0;
    @(negedge clk);
    while (d_req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    acc = cyc;
    checks++;
    if (d_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept ready=%b required 1", nm, d_req_ready);
      d_req_valid = 1'b0;
      return;
    end
    d_exp_q.push_back('{data: er, err: ee, name: nm});
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (d_rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (d_rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout d_rsp_valid=%b required 1", nm, d_rsp_valid);
    end else if (cyc - acc != WC + 1) begin
      errors++;
      $display("FAIL %s_latency cycles=%0d required %0d", nm, cyc - acc, WC + 1);
    end
  endtask

  task automatic fetch_txn(input logic [AW-1:0] a, input logic [31:0] er, input logic ee,
                           input string nm, output int acc);
    int n;
    if_req_valid = 1'b1; if_req_addr = a;
    n = 0;
    @(negedge clk);
    while (if_req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    acc = cyc;
    checks++;
    if (if_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept ready=%b required 1", nm, if_req_ready);
      if_req_valid = 1'b0;
      return;
    end
    if_exp_q.push_back('{data: er, err: ee, name: nm});
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (if_rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (if_rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout if_rsp_valid=%b required 1", nm, if_rsp_valid);
    end else if (cyc - acc != WC + 1) begin
      errors++;
      $display("FAIL %s_latency cycles=%0d required %0d", nm, cyc - acc, WC + 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    d_req_valid = 1'b1; if_req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (d_req_ready !== 1'b0 || if_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready d=%b if=%b required 0 0", d_req_ready, if_req_ready);
    end
    checks++;
    if (d_rsp_valid !== 1'b0 || d_rsp_rdata !== 32'h0 || d_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_d_rsp valid=%b rdata=%h err=%b required 0 0 0", d_rsp_valid, d_rsp_rdata, d_rsp_err);
    end
    checks++;
    if (if_rsp_valid !== 1'b0 || if_rsp_data !== 32'h0 || if_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_if_rsp valid=%b data=%h err=%b required 0 0 0", if_rsp_valid, if_rsp_data, if_rsp_err);
    end
    $display("ok   reset checked");
    @(posedge clk); #1;
    d_req_valid = 1'b0; if_req_valid = 1'b0; rst = 1'b0;
  endtask

  task automatic test_store_load();
    int acc;
    data_txn(1'b1, 3'b010, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0, "sw_010", acc);
    data_txn(1'b0, 3'b010, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, "lw_010", acc);
    data_txn(1'b1, 3'b010, 10'h000, 32'h55667788, 32'h0, 1'b0, "sw_000", acc);
    data_txn(1'b1, 3'b010, 10'h3FC, 32'hA1B2C3D4, 32'h0, 1'b0, "sw_3fc", acc);
    data_txn(1'b1, 3'b010, 10'h014, 32'h11223344, 32'h0, 1'b0, "sw_014", acc);
  endtask

  task automatic test_load_ext();
    int acc;
    data_txn(1'b0, 3'b000, 10'h013, 32'h0, 32'hFFFFFFDE, 1'b0, "lb_013", acc);
    data_txn(1'b0, 3'b100, 10'h013, 32'h0, 32'h000000DE, 1'b0, "lbu_013", acc);
    data_txn(1'b0, 3'b001, 10'h012, 32'h0, 32'hFFFFDEAD, 1'b0, "lh_012", acc);
    data_txn(1'b0, 3'b101, 10'h010, 32'h0, 32'h0000BEEF, 1'b0, "lhu_010", acc);
    data_txn(1'b0, 3'b000, 10'h011, 32'h0, 32'hFFFFFFBE, 1'b0, "lb_011", acc);
  endtask

  task automatic test_priority();
    int t, n;
    if_req_valid = 1'b1; if_req_addr = 10'h000;
    d_req_valid = 1'b1; d_req_write = 1'b0; d_req_func3 = 3'b010; d_req_addr = 10'h010;
    @(negedge clk);
    t = cyc;
    checks++;
    if (d_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_ready d=%b if=%b required 1 0", d_req_ready, if_req_ready);
    end
    d_exp_q.push_back('{data: 32'hDEADBEEF, err: 1'b0, name: "prio_lw_010"});
    if_exp_q.push_back('{data: 32'h55667788, err: 1'b0, name: "prio_fetch_000"});
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (if_req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (cyc - t != WC + 2) begin
      errors++;
      $display("FAIL prio_fetch_accept cycle=T+%0d required T+%0d", cyc - t, WC + 2);
    end
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (if_rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (cyc - t != 2 * WC + 3) begin
      errors++;
      $display("FAIL prio_fetch_rsp cycle=T+%0d required T+%0d", cyc - t, 2 * WC + 3);
    end
    checks++;
    if (d_rsp_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL prio_rdata_hold rdata=%h required deadbeef", d_rsp_rdata);
    end
  endtask

  task automatic test_fetch();
    int acc;
    fetch_txn(10'h012, 32'h3344DEAD, 1'b0, "fetch_012", acc);
    fetch_txn(10'h3FE, 32'h7788A1B2, 1'b0, "fetch_3fe_wrap", acc);
    fetch_txn(10'h011, 32'h0, 1'b1, "fetch_011_misalign", acc);
  endtask

  task automatic test_errors();
    int acc;
    data_txn(1'b1, 3'b001, 10'h011, 32'h0000FFFF, 32'h0, 1'b1, "sh_011_misalign", acc);
    data_txn(1'b0, 3'b010, 10'h012, 32'h0, 32'h0, 1'b1, "lw_012_misalign", acc);
    data_txn(1'b0, 3'b011, 10'h010, 32'h0, 32'h0, 1'b1, "ld_f3_011", acc);
    data_txn(1'b1, 3'b100, 10'h010, 32'h99999999, 32'h0, 1'b1, "st_f3_100", acc);
    data_txn(1'b0, 3'b010, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, "lw_010_unchanged", acc);
    data_txn(1'b1, 3'b000, 10'h011, 32'hFFFFFF99, 32'h0, 1'b0, "sb_011", acc);
    data_txn(1'b1, 3'b001, 10'h012, 32'h7777ABCD, 32'h0, 1'b0, "sh_012", acc);
    data_txn(1'b0, 3'b010, 10'h010, 32'h0, 32'hABCD99EF, 1'b0, "lw_010_partial", acc);
  endtask

  task automatic test_back_to_back();
    int a1, a2, a3;
    data_txn(1'b1, 3'b010, 10'h020, 32'h0BADF00D, 32'h0, 1'b0, "b2b_sw_020", a1);
    data_txn(1'b0, 3'b010, 10'h020, 32'h0, 32'h0BADF00D, 1'b0, "b2b_lw_020", a2);
    fetch_txn(10'h020, 32'h0BADF00D, 1'b0, "b2b_fetch_020", a3);
    checks++;
    if (a2 - a1 != WC + 2 || a3 - a2 != WC + 2) begin
      errors++;
      $display("FAIL b2b_throughput gaps=%0d,%0d required %0d", a2 - a1, a3 - a2, WC + 2);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    d_req_valid = 1'b1; d_req_write = 1'b1; d_req_func3 = 3'b010;
    d_req_addr = 10'h014; d_req_wdata = 32'hCAFEF00D;
    n = 0;
    @(negedge clk);
    while (d_req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    rst = 1'b1;
    d_req_write = 1'b0;
    @(negedge clk);
    checks++;
    if (d_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ready_in_rst ready=%b required 0", d_req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (d_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready_after ready=%b required 1", d_req_ready);
    end else d_exp_q.push_back('{data: 32'h11223344, err: 1'b0, name: "rstmid_lw_014"});
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    repeat (WC + 4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    if_req_valid = 1'b0; if_req_addr = '0;
    d_req_valid = 1'b0; d_req_write = 1'b0; d_req_addr = '0; d_req_wdata = '0; d_req_func3 = '0;
    test_reset();
    test_store_load();
    test_load_ext();
    test_priority();
    test_fetch();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    checks++;
    if (d_exp_q.size() != 0 || if_exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_responses d=%0d if=%0d required 0 0", d_exp_q.size(), if_exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
